fp_result_scoreboard: RTL and testbench
=======================================

Name: fp_result_scoreboard

Overview:
Downstream checking stage for the floating-point add/sub/mult DUTs.
- Stream interface in: expected results (from the float data loader), in issue order.
- Stream interface in: DUT results, qualified by the nonzero 3-bit output ID.
- Buffers expected values in an in-order FIFO, classifies every DUT result against the head entry, keeps saturating pass/warn/fail counters, and halts on a failure.
- Replaces the per-testbench ad-hoc checker loop; synthesizable, so it can also run on hardware.

Parameters:
pWidthExp, 8, exponent width
pWidthMan, 23, mantissa width (word width W = pWidthExp+pWidthMan+1)
pDepth, 16, expected-FIFO depth; power of 2, at least 2
pStopOnLsb, 1, 1 = a WARN_LSB verdict also halts the checker

Ports:
i_Clk  in  1  clock
i_SRstN  in  1  synchronous reset, active low
i_ExpDv  in  1  push the expected value
iv_Expected  in  W  expected result word
o_ExpReady  out  1  FIFO not full
i3_OutputID  in  3  DUT output ID; nonzero = DUT result valid
iv_Result  in  W  DUT result word
i_Overflow  in  1  DUT overflow flag, sampled with the result
o_CheckValid  out  1  one-cycle pulse: verdict valid
o3_Verdict  out  3  0 PASS, 1 WARN_LSB, 2 WARN_ZSIGN, 3 FAIL_INF, 4 FAIL_NAN, 5 FAIL_VALUE, 6 FAIL_ORPHAN
ov_PassCnt  out  32  saturating count of PASS verdicts
ov_WarnCnt  out  32  saturating count of WARN verdicts
ov_FailCnt  out  32  saturating count of FAIL verdicts
o_PushErr  out  1  sticky: a push arrived while the FIFO was full
o_Halted  out  1  sticky: the checker has stopped
o_Empty  out  1  FIFO empty

Behaviour:
- Clocking and reset:
  - Single clock domain: i_Clk. Reset is i_SRstN, synchronous, active low.
  - Reset values: all outputs 0 except o_ExpReady=1 and o_Empty=1. FIFO pointers cleared.
  - Reset mid-operation flushes the FIFO and discards any in-flight verdict. No o_CheckValid pulse is produced for the cycle in which reset is sampled.
- Push:
  - Accepted when i_ExpDv=1 and the FIFO is not full.
  - A push while full is dropped and sets o_PushErr.
  - A pop in the same cycle does not free space for that push; fullness is judged on the pre-cycle state.
- Check:
  - Triggered when i3_OutputID != 0 and o_Halted=0.
  - Pops the head entry when the FIFO is not empty.
  - The verdict is registered: o_CheckValid and o3_Verdict appear exactly one cycle after the DUT valid cycle. Counters update on that same edge.
  - Back-to-back DUT results give back-to-back verdicts, with no bubbles.
- Classification, applied in priority order to E = head entry, R = iv_Result:
  1. FIFO empty → FAIL_ORPHAN. A push in the same cycle is not bypassed.
  2. E is Inf (exponent all ones, mantissa 0) → PASS if i_Overflow=1, else FAIL_INF.
  3. E is NaN (exponent all ones, mantissa != 0) → PASS if R is any NaN, else FAIL_NAN.
  4. R == E → PASS.
  5. Unsigned W-bit difference |R−E| == 1 → WARN_LSB.
  6. R[W-2:0]==0 and E[W-2:0]==0 → WARN_ZSIGN.
  7. Otherwise → FAIL_VALUE.
- Halt:
  - Any FAIL verdict sets o_Halted on the same edge as o_CheckValid. WARN_LSB also sets it if pStopOnLsb=1.
  - While halted: no pops, no verdicts, counters frozen. Pushes are still accepted until the FIFO is full.
  - Only reset clears o_Halted.
- Counters saturate at 32'hFFFF_FFFF.
- The 2-state checker FSM is RUN → HALTED on a halting verdict, and HALTED → RUN only on reset.

Decomposition:
- Package fp_sb_pkg holds:
  - verdict code constants;
  - helper functions is_inf, is_nan, is_zero_mag, parameterized by exponent/mantissa width.
- Sub-module fp_sb_fifo: synchronous FIFO of pDepth × W with full/empty flags and a log2(pDepth)+1-bit pointer wrap.
- The classification comparator and the counters stay in the top module.

Test Plan:
- Push 3F800000, then DUT ID=1 with R=3F800000 → next cycle: o_CheckValid=1, verdict 0, PassCnt=1, o_Empty=1.
- Push 40000000, R=40000001 → verdict 1, WarnCnt=1. o_Halted=1 with pStopOnLsb=1; o_Halted=0 with pStopOnLsb=0.
- Push 80000000, R=00000000 → verdict 2, no halt.
- Push 7F800000 twice. First R=7F800000 with i_Overflow=1 → verdict 0. Second R=7F800000 with i_Overflow=0 → verdict 3, halt.
- Push 7FC00000, R=7F800001 → verdict 0. After reset, push 7FC00000, R=7F800000 → verdict 4.
- Push 17 times with no DUT output → entry 17 dropped, o_PushErr=1, o_ExpReady=0. Then reset: all counters 0, o_Empty=1. Then DUT valid with no push → verdict 6, FailCnt=1, o_Halted=1.

Source files
------------

// File: rtl/fp_sb_pkg.sv
// Shared verdict codes, checker state and IEEE-style field helpers for the FP result scoreboard.
// Helpers take the word zero-extended to SB_MAX_W plus the field widths, so one package serves any format.
package fp_sb_pkg;

   localparam int SB_MAX_W = 128;

   localparam logic [2:0] V_PASS        = 3'd0;
   localparam logic [2:0] V_WARN_LSB    = 3'd1;
   localparam logic [2:0] V_WARN_ZSIGN  = 3'd2;
   localparam logic [2:0] V_FAIL_INF    = 3'd3;
   localparam logic [2:0] V_FAIL_NAN    = 3'd4;
   localparam logic [2:0] V_FAIL_VALUE  = 3'd5;
   localparam logic [2:0] V_FAIL_ORPHAN = 3'd6;

   typedef enum logic {ST_RUN, ST_HALTED} sb_state_e;

   function automatic logic [SB_MAX_W-1:0] man_mask(input int wm);
      return (SB_MAX_W'(1) << wm) - SB_MAX_W'(1);
   endfunction

   function automatic logic [SB_MAX_W-1:0] exp_mask(input int we, input int wm);
      return ((SB_MAX_W'(1) << we) - SB_MAX_W'(1)) << wm;
   endfunction

   function automatic logic is_inf(input logic [SB_MAX_W-1:0] w, input int we, input int wm);
      return ((w & exp_mask(we, wm)) == exp_mask(we, wm)) && ((w & man_mask(wm)) == '0);
   endfunction

   function automatic logic is_nan(input logic [SB_MAX_W-1:0] w, input int we, input int wm);
      return ((w & exp_mask(we, wm)) == exp_mask(we, wm)) && ((w & man_mask(wm)) != '0);
   endfunction

   function automatic logic is_zero_mag(input logic [SB_MAX_W-1:0] w, input int we, input int wm);
      return (w & (exp_mask(we, wm) | man_mask(wm))) == '0;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

endpackage

// File: rtl/fp_sb_fifo.sv
// In-order FIFO of expected words; extra pointer bit distinguishes full from empty.
module fp_sb_fifo
#(
   parameter int pDepth = 16,
   parameter int pWidth = 32
)(
   input  logic              clk,
   input  logic              srst_n,
   input  logic              push,
   input  logic [pWidth-1:0] data,
   input  logic              pop,
   output logic [pWidth-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(pDepth);

   logic [pWidth-1:0] mem [pDepth];
   logic [AW:0]       wr_ptr, rd_ptr;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst_n && push && !full) mem[wr_ptr[AW-1:0]] <= data;
   end

endmodule

// File: rtl/fp_result_scoreboard.sv
// Checks DUT FP results in order against buffered expected words, counts verdicts, halts on failure.
module fp_result_scoreboard
   import fp_sb_pkg::*;
#(
   parameter int pWidthExp  = 8,
   parameter int pWidthMan  = 23,
   parameter int pDepth     = 16,
   parameter int pStopOnLsb = 1
)(
   input  logic                           i_Clk,
   input  logic                           i_SRstN,
   input  logic                           i_ExpDv,
   input  logic [pWidthExp+pWidthMan:0]   iv_Expected,
   output logic                           o_ExpReady,
   input  logic [2:0]                     i3_OutputID,
   input  logic [pWidthExp+pWidthMan:0]   iv_Result,
   input  logic                           i_Overflow,
   output logic                           o_CheckValid,
   output logic [2:0]                     o3_Verdict,
   output logic [31:0]                    ov_PassCnt,
   output logic [31:0]                    ov_WarnCnt,
   output logic [31:0]                    ov_FailCnt,
   output logic                           o_PushErr,
   output logic                           o_Halted,
   output logic                           o_Empty
);

   localparam int W = pWidthExp + pWidthMan + 1;

   logic [W-1:0] head, diff;
   logic         full, empty, check, halt_d;
   logic [2:0]   verdict_d;
   sb_state_e    state;

   // A check stalls entirely while halted, so the head is never consumed then.
   assign check      = (i3_OutputID != 3'd0) && (state == ST_RUN);
   assign o_ExpReady = !full;
   assign o_Empty    = empty;
   assign o_Halted   = (state == ST_HALTED);

   fp_sb_fifo #(.pDepth(pDepth), .pWidth(W)) u_fifo (
      .clk    (i_Clk),
      .srst_n (i_SRstN),
      .push   (i_ExpDv),
      .data   (iv_Expected),
      .pop    (check),
      .head   (head),
      .full   (full),
      .empty  (empty)
   );

   always_comb begin
      diff      = (iv_Result >= head) ? (iv_Result - head) : (head - iv_Result);
      verdict_d = V_FAIL_VALUE;
      if (empty)
         verdict_d = V_FAIL_ORPHAN;
      else if (is_inf(SB_MAX_W'(head), pWidthExp, pWidthMan))
         verdict_d = i_Overflow ? V_PASS : V_FAIL_INF;
      else if (is_nan(SB_MAX_W'(head), pWidthExp, pWidthMan))
         verdict_d = is_nan(SB_MAX_W'(iv_Result), pWidthExp, pWidthMan) ? V_PASS : V_FAIL_NAN;
      else if (iv_Result == head)
         verdict_d = V_PASS;
      else if (diff == W'(1))
         verdict_d = V_WARN_LSB;
      else if (is_zero_mag(SB_MAX_W'(iv_Result), pWidthExp, pWidthMan) &&
               is_zero_mag(SB_MAX_W'(head), pWidthExp, pWidthMan))
         verdict_d = V_WARN_ZSIGN;
      halt_d = (verdict_d >= V_FAIL_INF) || ((verdict_d == V_WARN_LSB) && (pStopOnLsb != 0));
   end

   always_ff @(posedge i_Clk) begin
      if (!i_SRstN) begin
         state        <= ST_RUN;
         o_CheckValid <= 1'b0;
         o3_Verdict   <= V_PASS;
         ov_PassCnt   <= '0;
         ov_WarnCnt   <= '0;
         ov_FailCnt   <= '0;
         o_PushErr    <= 1'b0;
      end else begin
         o_CheckValid <= check;
         if (i_ExpDv && full) o_PushErr <= 1'b1;
         if (check) begin
            o3_Verdict <= verdict_d;
            if (verdict_d == V_PASS)
               ov_PassCnt <= sat_inc(ov_PassCnt);
            else if (verdict_d <= V_WARN_ZSIGN)
               ov_WarnCnt <= sat_inc(ov_WarnCnt);
            else
               ov_FailCnt <= sat_inc(ov_FailCnt);
            if (halt_d) state <= ST_HALTED;
         end
      end
   end

endmodule

// File: tb/tb_fp_result_scoreboard.sv
// Drives two scoreboards (halt-on-LSB on and off) with shared stimulus and checks both against a queue model.
module tb_fp_result_scoreboard;

   logic        clk = 1'b0;
   logic        rstn, dv, ovf;
   logic [31:0] exp_w, res;
   logic [2:0]  id;

   logic        rdy [2], cv [2], perr [2], hlt [2], emp [2];
   logic [2:0]  vd [2];
   logic [31:0] pc [2], wc [2], fc [2];

   // model state per instance: index 0 = no halt on LSB, 1 = halt on LSB
   logic [31:0] q [2][$];
   logic [31:0] m_pc [2], m_wc [2], m_fc [2];
   logic        m_perr [2], m_hlt [2], m_cv [2];
   logic [2:0]  m_vd [2];
   int          tests = 0, fails = 0;

   always #5 clk = ~clk;

   fp_result_scoreboard #(.pWidthExp(8), .pWidthMan(23), .pDepth(16), .pStopOnLsb(0)) u_dut0 (
      .i_Clk(clk), .i_SRstN(rstn), .i_ExpDv(dv), .iv_Expected(exp_w), .o_ExpReady(rdy[0]),
      .i3_OutputID(id), .iv_Result(res), .i_Overflow(ovf), .o_CheckValid(cv[0]), .o3_Verdict(vd[0]),
      .ov_PassCnt(pc[0]), .ov_WarnCnt(wc[0]), .ov_FailCnt(fc[0]), .o_PushErr(perr[0]),
      .o_Halted(hlt[0]), .o_Empty(emp[0]));

   fp_result_scoreboard #(.pWidthExp(8), .pWidthMan(23), .pDepth(16), .pStopOnLsb(1)) u_dut1 (
      .i_Clk(clk), .i_SRstN(rstn), .i_ExpDv(dv), .iv_Expected(exp_w), .o_ExpReady(rdy[1]),
      .i3_OutputID(id), .iv_Result(res), .i_Overflow(ovf), .o_CheckValid(cv[1]), .o3_Verdict(vd[1]),
      .ov_PassCnt(pc[1]), .ov_WarnCnt(wc[1]), .ov_FailCnt(fc[1]), .o_PushErr(perr[1]),
      .o_Halted(hlt[1]), .o_Empty(emp[1]));

   function automatic logic [2:0] classify(input logic [31:0] e, input logic [31:0] r, input logic o);
      if (e[30:23] == 8'hFF) begin
         if (e[22:0] == 23'd0) return o ? 3'd0 : 3'd3;
         return (r[30:23] == 8'hFF && r[22:0] != 23'd0) ? 3'd0 : 3'd4;
      end
      if (r == e) return 3'd0;
      if ((r > e && r - e == 32'd1) || (e > r && e - r == 32'd1)) return 3'd1;
      if (r[30:0] == 31'd0 && e[30:0] == 31'd0) return 3'd2;
      return 3'd5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic model_edge(input int k);
      logic       was_full;
      logic [2:0] v;
      m_cv[k] = 1'b0;
      if (!rstn) begin
         q[k].delete();
         m_pc[k] = 0; m_wc[k] = 0; m_fc[k] = 0;
         m_perr[k] = 1'b0; m_hlt[k] = 1'b0; m_vd[k] = 3'd0;
         return;
      end
      was_full = (q[k].size() == 16);
      if (id != 3'd0 && !m_hlt[k]) begin
         m_cv[k] = 1'b1;
         if (q[k].size() == 0) v = 3'd6;
         else v = classify(q[k].pop_front(), res, ovf);
         m_vd[k] = v;
         if (v == 3'd0) m_pc[k]++;
         else if (v <= 3'd2) m_wc[k]++;
         else m_fc[k]++;
         if (v >= 3'd3 || (v == 3'd1 && k == 1)) m_hlt[k] = 1'b1;
      end
      if (dv) begin
         if (was_full) m_perr[k] = 1'b1;
         else q[k].push_back(exp_w);
      end
   endtask

   task automatic step(input logic r_n, input logic d, input logic [31:0] e,
                       input logic [2:0] i, input logic [31:0] r, input logic o);
      rstn = r_n; dv = d; exp_w = e; id = i; res = r; ovf = o;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("cv%0d", k), 32'(cv[k]), 32'(m_cv[k]));
         if (m_cv[k]) chk($sformatf("verdict%0d", k), 32'(vd[k]), 32'(m_vd[k]));
         chk($sformatf("pass%0d", k), pc[k], m_pc[k]);
         chk($sformatf("warn%0d", k), wc[k], m_wc[k]);
         chk($sformatf("fail%0d", k), fc[k], m_fc[k]);
         chk($sformatf("pusherr%0d", k), 32'(perr[k]), 32'(m_perr[k]));
         chk($sformatf("halted%0d", k), 32'(hlt[k]), 32'(m_hlt[k]));
         chk($sformatf("empty%0d", k), 32'(emp[k]), 32'(q[k].size() == 0));
         chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(q[k].size() < 16));
      end
   endtask

   task automatic push(input logic [31:0] e);
      step(1'b1, 1'b1, e, 3'd0, 32'd0, 1'b0);
   endtask

   task automatic dut(input logic [31:0] r, input logic o);
      step(1'b1, 1'b0, 32'd0, 3'd1, r, o);
   endtask

   task automatic reset();
      step(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, 1'b0);
   endtask

   initial begin
      logic [31:0] e, r, hd;
      reset();
      reset();
      chk("rst_verdict", 32'(vd[1]), 32'd0);
      chk("rst_cv", 32'(cv[1]), 32'd0);

      push(32'h3F80_0000); dut(32'h3F80_0000, 1'b0);
      chk("tp1_verdict", 32'(vd[1]), 32'd0);
      chk("tp1_pass", pc[1], 32'd1);

      push(32'h4000_0000); dut(32'h4000_0001, 1'b0);
      chk("tp2_verdict", 32'(vd[1]), 32'd1);
      chk("tp2_halt1", 32'(hlt[1]), 32'd1);
      chk("tp2_halt0", 32'(hlt[0]), 32'd0);
      reset();

      push(32'h8000_0000); dut(32'h0000_0000, 1'b0);
      chk("tp3_verdict", 32'(vd[1]), 32'd2);

      push(32'h7F80_0000); push(32'h7F80_0000);
      dut(32'h7F80_0000, 1'b1);
      chk("tp4_pass", 32'(vd[1]), 32'd0);
      dut(32'h7F80_0000, 1'b0);
      chk("tp4_inf", 32'(vd[1]), 32'd3);
      chk("tp4_halt", 32'(hlt[0]), 32'd1);
      dut(32'h7F80_0000, 1'b0);
      reset();

      push(32'h7FC0_0000); dut(32'h7F80_0001, 1'b0);
      chk("tp5_nanpass", 32'(vd[1]), 32'd0);
      reset();
      push(32'h7FC0_0000); dut(32'h7F80_0000, 1'b0);
      chk("tp5_nanfail", 32'(vd[1]), 32'd4);
      reset();

      for (int n = 0; n < 17; n++) push(32'(n) + 32'h3F80_0000);
      chk("tp6_perr", 32'(perr[1]), 32'd1);
      chk("tp6_ready", 32'(rdy[1]), 32'd0);
      dut(32'h3F80_0000, 1'b0);
      reset();
      dut(32'h0, 1'b0);
      chk("tp6_orphan", 32'(vd[1]), 32'd6);
      chk("tp6_failcnt", fc[1], 32'd1);

      // randomized phase; results are biased toward the model's current head
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 7))
            0: e = 32'h3F80_0000;
            1: e = 32'h0000_0000;
            2: e = 32'h8000_0000;
            3: e = 32'h7F80_0000;
            4: e = 32'hFF80_0000;
            5: e = 32'h7FC0_0000;
            default: e = $urandom;
         endcase
         hd = (q[0].size() != 0) ? q[0][0] : $urandom;
         case ($urandom_range(0, 6))
            0: r = hd;
            1: r = hd + 32'd1;
            2: r = hd - 32'd1;
            3: r = {~hd[31], 31'd0};
            4: r = 32'h7FC0_0000 | 32'($urandom_range(0, 7));
            5: r = 32'h7F80_0000;
            default: r = $urandom;
         endcase
         step(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1, e,
              ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0,
              r, $urandom_range(0, 1) == 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
